// File: rtl/alu_cond_unit.sv
// alu_cond_unit: control-side partner of the datapath ALU.
// Decodes op/funct into the ALU control code, derives NZCV from the ALU's
// operands and result, holds the architectural flags register and gates
// register, memory and PC writes with the instruction's condition field.
module alu_cond_unit #(
  parameter int N = 32
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_en,
  input  logic [3:0]   i_cond,
  input  logic [1:0]   i_op,
  input  logic [5:0]   i_funct,
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic [N-1:0] i_result,
  input  logic         i_reg_write_in,
  input  logic         i_mem_write_in,
  input  logic         i_pc_src_in,
  output logic [1:0]   o_alu_ctl,
  output logic         o_reg_write,
  output logic         o_mem_write,
  output logic         o_pc_src,
  output logic         o_cond_ex,
  output logic [3:0]   o_flags
);

  // Data-processing command encodings (funct[4:1])
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  // ALU control codes
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  // Instruction-class encodings (op)
  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;

  // Condition test against a {N,Z,C,V} flag vector
  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic fn, fz, fc, fv;
    logic res;
    fn = f[3];
    fz = f[2];
    fc = f[1];
    fv = f[0];
    case (c)
      4'b0000: res = fz;                         // EQ
      4'b0001: res = ~fz;                        // NE
      4'b0010: res = fc;                         // CS
      4'b0011: res = ~fc;                        // CC
      4'b0100: res = fn;                         // MI
      4'b0101: res = ~fn;                        // PL
      4'b0110: res = fv;                         // VS
      4'b0111: res = ~fv;                        // VC
      4'b1000: res = fc & ~fz;                   // HI
      4'b1001: res = ~fc | fz;                   // LS
      4'b1010: res = (fn == fv);                 // GE
      4'b1011: res = (fn != fv);                 // LT
      4'b1100: res = ~fz & (fn == fv);           // GT
      4'b1101: res = fz | (fn != fv);            // LE
      4'b1110: res = 1'b1;                       // AL
      default: res = 1'b0;                       // 1111: never
    endcase
    return res;
  endfunction

  logic [3:0]   r_flags;
  logic [3:0]   w_cmd;
  logic         w_s;
  logic         w_u;
  logic [1:0]   w_alu_ctl;
  logic         w_fw_nz;
  logic         w_fw_cv;
  logic         w_no_write;
  logic [N-1:0] w_nb;
  logic [N:0]   w_sum;
  logic         w_nf;
  logic         w_zf;
  logic         w_cf;
  logic         w_vf;
  logic         w_cond_ex;
  logic         w_ex;
  logic         w_unused;

  assign w_cmd = i_funct[4:1];
  assign w_s   = i_funct[0];
  assign w_u   = i_funct[3];

  // Decode ALU control, flag-write enables and the CMP write suppression
  always_comb begin
    w_alu_ctl  = ALU_ADD;
    w_fw_nz    = 1'b0;
    w_fw_cv    = 1'b0;
    w_no_write = 1'b0;
    case (i_op)
      OP_DP: begin
        case (w_cmd)
          CMD_ADD: begin
            w_alu_ctl = ALU_ADD;
            w_fw_nz   = w_s;
            w_fw_cv   = w_s;
          end
          CMD_SUB: begin
            w_alu_ctl = ALU_SUB;
            w_fw_nz   = w_s;
            w_fw_cv   = w_s;
          end
          CMD_CMP: begin
            // CMP exists only to set flags, so S is irrelevant
            w_alu_ctl  = ALU_SUB;
            w_fw_nz    = 1'b1;
            w_fw_cv    = 1'b1;
            w_no_write = 1'b1;
          end
          CMD_AND: begin
            w_alu_ctl = ALU_AND;
            w_fw_nz   = w_s;
          end
          CMD_ORR: begin
            w_alu_ctl = ALU_ORR;
            w_fw_nz   = w_s;
          end
          default: begin
            w_alu_ctl = ALU_ADD;
          end
        endcase
      end
      OP_MEM: begin
        // U selects whether the offset is added to or taken from the base
        if (w_u) begin
          w_alu_ctl = ALU_ADD;
        end else begin
          w_alu_ctl = ALU_SUB;
        end
      end
      default: begin
        w_alu_ctl = ALU_ADD;
      end
    endcase
  end

  // Rebuild the adder carry from the operands; N and Z come only from result
  assign w_nb  = w_alu_ctl[0] ? ~i_b : i_b;
  assign w_sum = {1'b0, i_a} + {1'b0, w_nb} + {{N{1'b0}}, w_alu_ctl[0]};
  assign w_nf  = i_result[N-1];
  assign w_zf  = (i_result == {N{1'b0}});
  assign w_cf  = w_sum[N];
  assign w_vf  = (i_a[N-1] == w_nb[N-1]) & (i_result[N-1] != i_a[N-1]);

  // Condition uses the registered flags; new flags are never forwarded
  assign w_cond_ex = cond_pass(i_cond, r_flags);
  assign w_ex      = i_en & w_cond_ex;

  assign o_alu_ctl   = w_alu_ctl;
  assign o_cond_ex   = w_cond_ex;
  assign o_reg_write = i_reg_write_in & w_ex & ~w_no_write;
  assign o_mem_write = i_mem_write_in & w_ex;
  assign o_pc_src    = i_pc_src_in & w_ex;
  assign o_flags     = r_flags;

  assign w_unused = &{1'b0, i_funct[5], w_sum[N-1:0]};

  // Architectural flags register: N/Z and C/V groups update independently
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_flags <= 4'b0000;
    end else if (w_ex) begin
      if (w_fw_nz) begin
        r_flags[3:2] <= {w_nf, w_zf};
      end
      if (w_fw_cv) begin
        r_flags[1:0] <= {w_cf, w_vf};
      end
    end
  end

endmodule

// File: tb/tb_alu_cond_unit.sv
// Self-checking bench for alu_cond_unit: directed scenarios followed by
// randomized instructions, all checked against a behavioural flag model.
module tb_alu_cond_unit;

  logic        clk;
  logic        rst;
  logic        en;
  logic [3:0]  cond;
  logic [1:0]  op;
  logic [5:0]  funct;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] result;
  logic        rwi;
  logic        mwi;
  logic        psi;
  logic [1:0]  alu_ctl;
  logic        reg_write;
  logic        mem_write;
  logic        pc_src;
  logic        cond_ex;
  logic [3:0]  flags;

  int passed = 0;
  int total  = 0;

  // model flags
  bit mN, mZ, mC, mV;

  alu_cond_unit #(.N(32)) dut (
    .i_clk(clk), .i_reset(rst), .i_en(en), .i_cond(cond), .i_op(op),
    .i_funct(funct), .i_a(a), .i_b(b), .i_result(result),
    .i_reg_write_in(rwi), .i_mem_write_in(mwi), .i_pc_src_in(psi),
    .o_alu_ctl(alu_ctl), .o_reg_write(reg_write), .o_mem_write(mem_write),
    .o_pc_src(pc_src), .o_cond_ex(cond_ex), .o_flags(flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic bit model_cond(input logic [3:0] c);
    case (c)
      4'd0:  return mZ;
      4'd1:  return !mZ;
      4'd2:  return mC;
      4'd3:  return !mC;
      4'd4:  return mN;
      4'd5:  return !mN;
      4'd6:  return mV;
      4'd7:  return !mV;
      4'd8:  return mC && !mZ;
      4'd9:  return !mC || mZ;
      4'd10: return mN == mV;
      4'd11: return mN != mV;
      4'd12: return !mZ && (mN == mV);
      4'd13: return mZ || (mN != mV);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Which operation the ALU performs: 0 add, 1 sub, 2 and, 3 or
  function automatic int model_kind(input logic [1:0] o, input logic [5:0] f);
    int cmd;
    cmd = int'(f[4:1]);
    if (o == 2'd0) begin
      if (cmd == 4) return 0;
      if (cmd == 2 || cmd == 10) return 1;
      if (cmd == 0) return 2;
      if (cmd == 12) return 3;
      return 0;
    end
    if (o == 2'd1) return f[3] ? 0 : 1;
    return 0;
  endfunction

  // Apply one instruction, check same-cycle outputs, clock it, update model
  task automatic step(input logic e, input logic [3:0] c, input logic [1:0] o,
                      input logic [5:0] f, input logic [31:0] x, input logic [31:0] y,
                      input logic rw, input logic mw, input logic ps);
    int     kind;
    int     cmd;
    bit     pass;
    bit     is_cmp, arith, logical;
    longint sx, sy, sr;
    longint ux, uy;
    logic [31:0] r;
    kind = model_kind(o, f);
    case (kind)
      0: r = x + y;
      1: r = x - y;
      2: r = x & y;
      default: r = x | y;
    endcase
    en = e; cond = c; op = o; funct = f; a = x; b = y; result = r;
    rwi = rw; mwi = mw; psi = ps;
    cmd = int'(f[4:1]);
    is_cmp  = (o == 2'd0) && (cmd == 10);
    arith   = (o == 2'd0) && (cmd == 4 || cmd == 2 || cmd == 10);
    logical = (o == 2'd0) && (cmd == 0 || cmd == 12);
    pass = model_cond(c);
    #2;
    check("alu_ctl", {30'd0, alu_ctl}, kind);
    check("cond_ex", {31'd0, cond_ex}, {31'd0, pass});
    check("reg_write", {31'd0, reg_write}, {31'd0, rw && e && pass && !is_cmp});
    check("mem_write", {31'd0, mem_write}, {31'd0, mw && e && pass});
    check("pc_src", {31'd0, pc_src}, {31'd0, ps && e && pass});
    check("flags", {28'd0, flags}, {28'd0, mN, mZ, mC, mV});
    @(posedge clk);
    if (rst) begin
      {mN, mZ, mC, mV} = 4'b0000;
    end else if (e && pass) begin
      if (is_cmp || (f[0] && (arith || logical))) begin
        mN = r[31];
        mZ = (r == 32'd0);
      end
      if (is_cmp || (f[0] && arith)) begin
        sx = $signed(x);
        sy = $signed(y);
        ux = x;
        uy = y;
        if (kind == 0) begin
          mC = (ux + uy) >= 64'sh1_0000_0000;
          sr = sx + sy;
        end else begin
          mC = (ux >= uy);
          sr = sx - sy;
        end
        mV = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
    end
    #1;
  endtask

  localparam logic [5:0] F_SUBS = 6'b000101;
  localparam logic [5:0] F_ADDS = 6'b001001;
  localparam logic [5:0] F_ANDS = 6'b000001;
  localparam logic [5:0] F_CMP  = 6'b010100;
  localparam logic [3:0] C_EQ = 4'd0, C_NE = 4'd1, C_GE = 4'd10, C_LT = 4'd11;
  localparam logic [3:0] C_AL = 4'd14, C_NV = 4'd15;

  initial begin
    int cmds[6];
    logic [5:0]  rf;
    logic [31:0] ra, rb;
    cmds = '{4, 2, 10, 0, 12, 7};
    rst = 1'b1; en = 1'b0; cond = 4'd0; op = 2'd0; funct = 6'd0;
    a = 32'd0; b = 32'd0; result = 32'd0; rwi = 1'b0; mwi = 1'b0; psi = 1'b0;
    #1;
    check("reset_flags", {28'd0, flags}, 32'd0);
    @(posedge clk); #1;

    // Flag-setting instruction while reset held: flags must stay clear
    step(1'b1, C_AL, 2'd0, F_SUBS, 32'd5, 32'd5, 1'b1, 1'b0, 1'b0);
    check("reset_hold", {28'd0, flags}, 32'd0);
    rst = 1'b0;

    // Stray flags, then async reset between edges
    step(1'b1, C_AL, 2'd0, F_ADDS, 32'h7FFF_FFFF, 32'd1, 1'b1, 1'b0, 1'b0);
    check("stray_flags", {28'd0, flags}, 32'h9);
    rst = 1'b1;
    #1;
    check("async_reset", {28'd0, flags}, 32'd0);
    {mN, mZ, mC, mV} = 4'b0000;
    rst = 1'b0;
    step(1'b1, C_EQ, 2'd2, 6'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    step(1'b1, C_NE, 2'd2, 6'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);

    // SUBS equal operands -> Z and C, then EQ branch taken
    step(1'b1, C_AL, 2'd0, F_SUBS, 32'd5, 32'd5, 1'b1, 1'b0, 1'b0);
    check("subs_flags", {28'd0, flags}, 32'h6);
    step(1'b1, C_EQ, 2'd2, 6'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);

    // ADDS signed overflow -> N and V; GE fails, LT passes
    step(1'b1, C_AL, 2'd0, F_ADDS, 32'h7FFF_FFFF, 32'd1, 1'b1, 1'b0, 1'b0);
    check("adds_flags", {28'd0, flags}, 32'h9);
    step(1'b1, C_GE, 2'd2, 6'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    step(1'b1, C_LT, 2'd2, 6'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);

    // ANDS keeps C and V
    step(1'b1, C_AL, 2'd0, F_SUBS, 32'd5, 32'd5, 1'b1, 1'b0, 1'b0);
    step(1'b1, C_AL, 2'd0, F_ANDS, 32'h0000_00F0, 32'h0000_000F, 1'b1, 1'b0, 1'b0);
    check("ands_keep_c", {28'd0, flags}, 32'h6);

    // Conditional CMP that fails on clear flags
    rst = 1'b1; #1; rst = 1'b0;
    {mN, mZ, mC, mV} = 4'b0000;
    step(1'b1, C_EQ, 2'd0, F_CMP, 32'd3, 32'd3, 1'b1, 1'b0, 1'b0);
    check("cmp_skipped", {28'd0, flags}, 32'd0);
    // CMP passing with S=0 still writes flags
    step(1'b1, C_AL, 2'd0, F_CMP, 32'd3, 32'd3, 1'b1, 1'b0, 1'b0);
    check("cmp_no_s", {28'd0, flags}, 32'h6);

    // Memory ops: U selects add/sub; never-condition and en=0 block writes
    step(1'b1, C_NV, 2'd1, 6'b000000, 32'd100, 32'd4, 1'b0, 1'b1, 1'b0);
    step(1'b1, C_NV, 2'd1, 6'b001000, 32'd100, 32'd4, 1'b0, 1'b1, 1'b0);
    step(1'b0, C_AL, 2'd1, 6'b001000, 32'd100, 32'd4, 1'b1, 1'b1, 1'b1);
    step(1'b1, C_AL, 2'd1, 6'b000000, 32'd100, 32'd4, 1'b1, 1'b1, 1'b0);

    // Randomized instructions
    for (int i = 0; i < 400; i++) begin
      rf = 6'($urandom);
      rf[4:1] = 4'(cmds[$urandom_range(0, 5)]);
      ra = $urandom;
      rb = ($urandom_range(0, 4) == 0) ? ra : 32'($urandom);
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      step(($urandom_range(0, 4) != 0),
           ($urandom_range(0, 2) == 0) ? C_AL : 4'($urandom),
           ($urandom_range(0, 2) != 0) ? 2'd0 : 2'($urandom),
           rf, ra, rb, 1'($urandom), 1'($urandom), 1'($urandom));
    end
    step(1'b0, C_AL, 2'd2, 6'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alu_cond_unit.md
# alu_cond_unit

Control-side partner of the datapath ALU. Decodes the instruction's op/funct fields into the 2-bit `alu_ctl` that drives the ALU, and computes NZCV from the ALU's operands and result. Holds the architectural flags register and evaluates the 4-bit condition field, gating register, memory and PC writes. Sits between the main decoder and the datapath in the single-cycle ARM core.

## Interface
- `N`, 32: datapath width; must match the ALU.

- `clk`  in  1: clock; rising edge.
- `reset`  in  1: asynchronous, active-high.
- `en`  in  1: instruction valid this cycle.
- `cond`  in  4: instr[31:28].
- `op`  in  2: instr[27:26].
- `funct`  in  6: instr[25:20]; funct[4:1] = cmd, funct[0] = S, funct[3] = U for memory ops.
- `a`, `b`  in  N: ALU operands, as presented to the ALU.
- `result`  in  N: ALU result for the same cycle.
- `reg_write_in`, `mem_write_in`, `pc_src_in`  in  1 each: unconditional write intents from the main decoder.
- `alu_ctl`  out  2: 00 add, 01 sub, 10 and, 11 or.
- `reg_write`, `mem_write`, `pc_src`  out  1 each: qualified writes.
- `cond_ex`  out  1: condition passed.
- `flags`  out  4: registered {N,Z,C,V}.

## Operation
- ALU control decode (combinational):
  - op=00: cmd 0100 ADD→00; 0010 SUB→01; 1010 CMP→01; 0000 AND→10; 1100 ORR→11; any other cmd→00.
  - op=01: U=1→00, U=0→01.
  - op=10: 00. op=11: 00.
- No-write: op=00 and cmd=1010 (CMP) suppresses `reg_write`.
- Flag-write enables, op=00 only:
  - fw_nz = S for ADD, SUB, CMP, AND, ORR.
  - fw_cv = S for ADD, SUB, CMP only. Logic ops preserve C and V.
  - CMP sets flags regardless of S.
  - Unsupported cmd: no flag writes.
- Flag computation, from inputs:
  - nb = alu_ctl[0] ? ~b : b.
  - s = {1'b0,a} + {1'b0,nb} + alu_ctl[0], N+1 bits.
  - Nf = result[N-1]; Zf = (result == 0); Cf = s[N].
  - Vf = (a[N-1] == nb[N-1]) & (result[N-1] != a[N-1]).
- Condition evaluation uses the current registered `flags`:
  - EQ Z; NE ~Z; CS C; CC ~C; MI N; PL ~N; VS V; VC ~V.
  - HI C&~Z; LS ~C|Z; GE N==V; LT N!=V; GT ~Z&(N==V); LE Z|(N!=V).
  - 1110 AL = 1; 1111 = 0 (never).
- Qualified outputs:
  - ex = en & cond_ex.
  - reg_write = reg_write_in & ex & ~no_write.
  - mem_write = mem_write_in & ex.
  - pc_src = pc_src_in & ex.
- Flags register update on `clk` rising edge when ex:
  - If fw_nz: {N,Z} ← {Nf,Zf}.
  - If fw_cv: {C,V} ← {Cf,Vf}.
  - Otherwise each field holds.

## Timing
- Decode, flag computation, cond_ex and qualified writes are combinational, in the same cycle as inputs.
- Flags written at edge k are visible on `flags` and used by cond_ex from cycle k+1.
- Same-cycle read/write: a flag-setting conditional instruction evaluates its condition on the old flags. New flags are never forwarded.
- en=0: all qualified writes are 0 and flags hold. `alu_ctl` still decodes.
- Reset:
  - `reset` high clears flags to 0000 immediately, independent of `clk`.
  - While high, flags stay 0000 and edges do not update them.
  - Combinational outputs keep following inputs using flags=0000.
  - Reset mid-instruction discards any pending flag write.
- After reset, EQ fails, NE passes, AL passes.
- Widths: s is N+1 bits; only `result` drives N/Z. Carry on subtract follows ARM convention: C=1 means no borrow.

## Test plan
- Reset with stray flags, then `reset`=1 between edges → `flags`=0000 immediately. Release, then cond=0000 (EQ) → cond_ex=0; cond=0001 → cond_ex=1.
- SUBS (op=00, funct=000101), a=b=5, result=0, cond=AL → alu_ctl=01. Next cycle flags=0110 (Z=1, C=1). Then cond=EQ, pc_src_in=1 → pc_src=1.
- ADDS, a=0x7FFFFFFF, b=1, result=0x80000000 → next flags=1001 (N=1, V=1). Following cond=GE → cond_ex=0; cond=LT → cond_ex=1.
- With flags=0110, ANDS, a=0xF0, b=0x0F, result=0 → next flags=0110. C is retained, not recomputed.
- With flags=0000, conditional CMP (cond=EQ), a=b=3, reg_write_in=1 → cond_ex=0 and reg_write=0. Next cycle flags remain 0000.
- Memory op, op=01, U=0 → alu_ctl=01. U=1 → 00. Both with cond=1111: mem_write=0 and flags unchanged. Same op with en=0 and cond=AL → mem_write=0.
